uart_boot_loader: RTL and testbench

- Sits upstream of the pipelined MIPS datapath on the top-level rx pin.
- Receives 8N1 UART bytes and assembles them big-endian into 32-bit instructions.
- Writes each instruction into instruction memory at sequential byte addresses (0, 4, 8, …) and holds the CPU until the program is loaded.
- Frees the CPU for fetch from PC=0 when loading ends.

---
 rtl/uart_pkg.sv | 33 +++
 rtl/uart_rx_core.sv | 153 +++++++++++++++
 rtl/uart_boot_loader.sv | 126 ++++++++++++
 tb/tb_uart_boot_loader.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART boot loader.
//   rx_state_t  : receiver FSM encoding
//   ld_state_t  : loader FSM encoding
//   END_MARKER  : word that terminates a program load
//   calc_div()  : clocks per oversample tick, rounded to nearest
package uart_pkg;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_BREAK
    } rx_state_t;

    typedef enum logic {
        LD_LOAD,
        LD_DONE
    } ld_state_t;

    localparam logic [31:0] END_MARKER = 32'hFFFF_FFFF;

    function automatic int unsigned calc_div(input int unsigned clk_hz,
                                             input int unsigned baud,
                                             input int unsigned oversample);
        int unsigned den;
        int unsigned div;
        den = baud * oversample;
        div = (clk_hz + den / 2) / den;
        return (div == 0) ? 1 : div;
    endfunction

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: 2-FF input synchronizer, free-running oversample tick
// generator and the receive FSM.
//   clk, reset : system clock, async active-low reset
//   rx         : raw serial input (idle high)
//   rx_valid   : 1-clk pulse, rx_byte holds the received byte
//   rx_byte    : last received byte
//   rx_ferr    : 1-clk pulse when a byte fails its stop bit
//
// state    | meaning
// ---------+-------------------------------------------------------
// RX_IDLE  | line idle, waiting for a falling edge
// RX_START | counting to mid start bit, confirming it is still low
// RX_DATA  | sampling 8 data bits LSB first, one per bit period
// RX_STOP  | sampling the stop bit
// RX_BREAK | stop bit was low; wait for the line to return high
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 50000000,
    parameter int unsigned BAUD       = 19200,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic       rx_valid,
    output logic [7:0] rx_byte,
    output logic       rx_ferr
);

    localparam int unsigned DIV   = calc_div(CLK_HZ, BAUD, OVERSAMPLE);
    localparam int unsigned DIV_W = (DIV > 2) ? $clog2(DIV) : 1;
    localparam int unsigned OS_W  = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;

    localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(DIV - 1);
    localparam logic [OS_W-1:0]  OS_FULL    = OS_W'(OVERSAMPLE - 1);
    localparam logic [OS_W-1:0]  OS_HALF    = OS_W'(OVERSAMPLE / 2 - 1);

    logic [1:0]       sync_q, sync_d;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    rx_state_t        state_q, state_d;
    logic [OS_W-1:0]  os_cnt_q, os_cnt_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shreg_q, shreg_d;
    logic             rx_valid_q, rx_valid_d;
    logic [7:0]       rx_byte_q, rx_byte_d;
    logic             rx_ferr_q, rx_ferr_d;

    logic rx_s;
    logic tick;
    logic os_done;

    assign rx_s    = sync_q[1];
    assign tick    = (div_cnt_q == '0);
    assign os_done = tick && (os_cnt_q == '0);

    always_comb begin
        sync_d    = {sync_q[0], rx};
        div_cnt_d = tick ? DIV_RELOAD : div_cnt_q - 1'b1;
    end

    always_comb begin
        state_d    = state_q;
        os_cnt_d   = os_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shreg_d    = shreg_q;
        rx_valid_d = 1'b0;
        rx_byte_d  = rx_byte_q;
        rx_ferr_d  = 1'b0;

        if (tick && (os_cnt_q != '0)) begin
            os_cnt_d = os_cnt_q - 1'b1;
        end

        case (state_q)
            RX_IDLE: begin
                if (!rx_s) begin
                    state_d  = RX_START;
                    os_cnt_d = OS_HALF;
                end
            end
            RX_START: begin
                if (os_done) begin
                    if (!rx_s) begin
                        state_d   = RX_DATA;
                        os_cnt_d  = OS_FULL;
                        bit_cnt_d = 3'd7;
                    end else begin
                        state_d = RX_IDLE;
                    end
                end
            end
            RX_DATA: begin
                if (os_done) begin
                    shreg_d  = {rx_s, shreg_q[7:1]};
                    os_cnt_d = OS_FULL;
                    if (bit_cnt_q == 3'd0) begin
                        state_d = RX_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q - 3'd1;
                    end
                end
            end
            RX_STOP: begin
                if (os_done) begin
                    if (rx_s) begin
                        rx_valid_d = 1'b1;
                        rx_byte_d  = shreg_q;
                        state_d    = RX_IDLE;
                    end else begin
                        rx_ferr_d = 1'b1;
                        state_d   = RX_BREAK;
                    end
                end
            end
            RX_BREAK: begin
                if (rx_s) begin
                    state_d = RX_IDLE;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q     <= 2'b11;
            div_cnt_q  <= DIV_RELOAD;
            state_q    <= RX_IDLE;
            os_cnt_q   <= '0;
            bit_cnt_q  <= '0;
            shreg_q    <= '0;
            rx_valid_q <= 1'b0;
            rx_byte_q  <= '0;
            rx_ferr_q  <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            div_cnt_q  <= div_cnt_d;
            state_q    <= state_d;
            os_cnt_q   <= os_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shreg_q    <= shreg_d;
            rx_valid_q <= rx_valid_d;
            rx_byte_q  <= rx_byte_d;
            rx_ferr_q  <= rx_ferr_d;
        end
    end

    assign rx_valid = rx_valid_q;
    assign rx_byte  = rx_byte_q;
    assign rx_ferr  = rx_ferr_q;

endmodule

// File: rtl/uart_boot_loader.sv
// UART boot loader: assembles received bytes big-endian into 32-bit words and
// writes them to instruction memory at 0, 4, 8, ... while holding the CPU.
//   clk, reset  : system clock, async active-low reset
//   rx          : UART serial input
//   imem_we     : 1-clk write strobe, with imem_addr / imem_din
//   cpu_hold    : 1 while loading
//   load_done   : sticky, program loaded (end marker or capacity)
//   frame_err   : sticky, a byte failed its stop bit
//   word_count  : words written so far
//
// state   | meaning
// --------+-----------------------------------------------------------
// LD_LOAD | assembling bytes into words and writing them to imem
// LD_DONE | load finished, CPU released, rx bytes ignored until reset
module uart_boot_loader
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 50000000,
    parameter int unsigned BAUD       = 19200,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned MAX_WORDS  = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_din,
    output logic        cpu_hold,
    output logic        load_done,
    output logic        frame_err,
    output logic [10:0] word_count
);

    logic       rx_valid;
    logic [7:0] rx_byte;
    logic       rx_ferr;

    uart_rx_core #(
        .CLK_HZ     (CLK_HZ),
        .BAUD       (BAUD),
        .OVERSAMPLE (OVERSAMPLE)
    ) u_rx (
        .clk      (clk),
        .reset    (reset),
        .rx       (rx),
        .rx_valid (rx_valid),
        .rx_byte  (rx_byte),
        .rx_ferr  (rx_ferr)
    );

    ld_state_t   ld_state_q, ld_state_d;
    logic [31:0] shreg_q, shreg_d;
    logic [1:0]  byte_idx_q, byte_idx_d;
    logic        imem_we_q, imem_we_d;
    logic [31:0] imem_addr_q, imem_addr_d;
    logic [31:0] imem_din_q, imem_din_d;
    logic [10:0] word_count_q, word_count_d;
    logic        frame_err_q, frame_err_d;

    logic [31:0] word_next;

    assign word_next = {shreg_q[23:0], rx_byte};

    always_comb begin
        ld_state_d   = ld_state_q;
        shreg_d      = shreg_q;
        byte_idx_d   = byte_idx_q;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_din_d   = imem_din_q;
        word_count_d = word_count_q;
        frame_err_d  = frame_err_q | rx_ferr;

        if ((ld_state_q == LD_LOAD) && rx_valid) begin
            shreg_d    = word_next;
            byte_idx_d = byte_idx_q + 2'd1;
            if (byte_idx_q == 2'd3) begin
                if (word_next == END_MARKER) begin
                    ld_state_d = LD_DONE;
                end else begin
                    // Registered strobe: the write appears the cycle after the
                    // 4th byte, carrying the pre-increment address.
                    imem_we_d    = 1'b1;
                    imem_din_d   = word_next;
                    imem_addr_d  = {19'd0, word_count_q, 2'b00};
                    word_count_d = word_count_q + 11'd1;
                    if ((32'(word_count_q) + 32'd1) == 32'(MAX_WORDS)) begin
                        ld_state_d = LD_DONE;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ld_state_q   <= LD_LOAD;
            shreg_q      <= '0;
            byte_idx_q   <= '0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_din_q   <= '0;
            word_count_q <= '0;
            frame_err_q  <= 1'b0;
        end else begin
            ld_state_q   <= ld_state_d;
            shreg_q      <= shreg_d;
            byte_idx_q   <= byte_idx_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_din_q   <= imem_din_d;
            word_count_q <= word_count_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_din   = imem_din_q;
    assign word_count = word_count_q;
    assign frame_err  = frame_err_q;
    assign load_done  = (ld_state_q == LD_DONE);
    assign cpu_hold   = (ld_state_q != LD_DONE);

endmodule

// File: tb/tb_uart_boot_loader.sv
module tb_uart_boot_loader;
    import uart_pkg::*;

    localparam int unsigned CLK_HZ   = 1228800;
    localparam int unsigned BAUD     = 19200;
    localparam int unsigned OS       = 16;
    localparam int          BIT_CLKS = 64;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] din;
        logic [10:0] cnt;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        rx = 1'b1;
    logic        rx_c = 1'b1;

    logic        imem_we,   imem_we_c;
    logic [31:0] imem_addr, imem_addr_c;
    logic [31:0] imem_din,  imem_din_c;
    logic        cpu_hold,  cpu_hold_c;
    logic        load_done, load_done_c;
    logic        frame_err, frame_err_c;
    logic [10:0] word_count, word_count_c;

    int checks = 0;
    int failures = 0;
    int wr_cnt = 0;
    int rxv_cnt = 0;

    wr_t exp_q[$];
    wr_t exp_c_q[$];

    always #5 clk = ~clk;

    uart_boot_loader #(
        .CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVERSAMPLE(OS), .MAX_WORDS(1024)
    ) dut (
        .clk(clk), .reset(reset), .rx(rx),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_din(imem_din),
        .cpu_hold(cpu_hold), .load_done(load_done), .frame_err(frame_err),
        .word_count(word_count)
    );

    uart_boot_loader #(
        .CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVERSAMPLE(OS), .MAX_WORDS(2)
    ) dut_c (
        .clk(clk), .reset(reset), .rx(rx_c),
        .imem_we(imem_we_c), .imem_addr(imem_addr_c), .imem_din(imem_din_c),
        .cpu_hold(cpu_hold_c), .load_done(load_done_c), .frame_err(frame_err_c),
        .word_count(word_count_c)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop, input bit cap);
        logic [9:0] frame;
        frame = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            if (cap) rx_c = frame[i];
            else     rx   = frame[i];
            wait_clks(BIT_CLKS);
        end
        if (cap) rx_c = 1'b1;
        else     rx   = 1'b1;
        wait_clks(16);
    endtask

    task automatic send_word(input logic [31:0] w, input bit cap);
        logic [31:0] t;
        t = w;
        for (int i = 0; i < 4; i++) begin
            send_byte(t[31:24], 1'b1, cap);
            t = t << 8;
        end
    endtask

    // Monitor for the main instance.
    logic rxv_prev = 1'b0;
    logic we_prev = 1'b0;
    always @(negedge clk) begin
        wr_t e;
        if (dut.rx_valid) rxv_cnt++;
        if (imem_we) begin
            wr_cnt++;
            check("wr_single_cycle", {31'd0, we_prev}, 32'd0);
            check("wr_latency", {31'd0, rxv_prev}, 32'd1);
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write addr=%h din=%h required=no_write", imem_addr, imem_din);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", imem_addr, e.addr);
                check("wr_din", imem_din, e.din);
                check("wr_count", {21'd0, word_count}, {21'd0, e.cnt});
            end
        end
        rxv_prev = dut.rx_valid;
        we_prev  = imem_we;
    end

    // Monitor for the MAX_WORDS=2 instance.
    logic rxv_prev_c = 1'b0;
    always @(negedge clk) begin
        wr_t e;
        if (imem_we_c) begin
            check("cap_wr_latency", {31'd0, rxv_prev_c}, 32'd1);
            if (exp_c_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL cap_unexpected_write addr=%h din=%h required=no_write", imem_addr_c, imem_din_c);
            end else begin
                e = exp_c_q.pop_front();
                check("cap_wr_addr", imem_addr_c, e.addr);
                check("cap_wr_din", imem_din_c, e.din);
                check("cap_wr_count", {21'd0, word_count_c}, {21'd0, e.cnt});
            end
        end
        rxv_prev_c = dut_c.rx_valid;
    end

    initial begin
        int rxv_before;

        // Reset behaviour with rx toggling.
        reset = 1'b0;
        for (int i = 0; i < 40; i++) begin
            rx = i[0];
            wait_clks(3);
        end
        rx = 1'b1;
        check("rst_imem_we", {31'd0, imem_we}, 32'd0);
        check("rst_imem_addr", imem_addr, 32'd0);
        check("rst_imem_din", imem_din, 32'd0);
        check("rst_word_count", {21'd0, word_count}, 32'd0);
        check("rst_cpu_hold", {31'd0, cpu_hold}, 32'd1);
        check("rst_load_done", {31'd0, load_done}, 32'd0);
        check("rst_frame_err", {31'd0, frame_err}, 32'd0);
        wait_clks(5);
        reset = 1'b1;
        wait_clks(300);
        check("no_write_after_reset", wr_cnt, 32'd0);

        // Word load.
        exp_q.push_back('{addr: 32'h0, din: 32'h2008_0005, cnt: 11'd1});
        send_word(32'h2008_0005, 1'b0);
        exp_q.push_back('{addr: 32'h4, din: 32'h0000_0000, cnt: 11'd2});
        send_word(32'h0000_0000, 1'b0);
        wait_clks(10);
        check("load_word_count", {21'd0, word_count}, 32'd2);
        check("load_cpu_hold", {31'd0, cpu_hold}, 32'd1);

        // Third word then end marker.
        exp_q.push_back('{addr: 32'h8, din: 32'h8C09_0004, cnt: 11'd3});
        send_word(32'h8C09_0004, 1'b0);
        send_word(32'hFFFF_FFFF, 1'b0);
        wait_clks(10);
        check("end_word_count", {21'd0, word_count}, 32'd3);
        check("end_load_done", {31'd0, load_done}, 32'd1);
        check("end_cpu_hold", {31'd0, cpu_hold}, 32'd0);
        check("end_writes", wr_cnt, 32'd3);
        send_word(32'h1212_1212, 1'b0);
        wait_clks(10);
        check("done_ignores_writes", wr_cnt, 32'd3);
        check("done_word_count", {21'd0, word_count}, 32'd3);

        // Framing error with held-low line.
        reset = 1'b0;
        wait_clks(5);
        check("rst2_load_done", {31'd0, load_done}, 32'd0);
        check("rst2_cpu_hold", {31'd0, cpu_hold}, 32'd1);
        reset = 1'b1;
        wait_clks(20);
        rxv_before = rxv_cnt;
        rx = 1'b0;
        wait_clks(BIT_CLKS);
        for (int i = 0; i < 8; i++) begin
            rx = (8'h11 >> i) & 1'b1;
            wait_clks(BIT_CLKS);
        end
        rx = 1'b0;
        wait_clks(BIT_CLKS + 3 * BIT_CLKS);
        check("ferr_set", {31'd0, frame_err}, 32'd1);
        check("break_no_byte", rxv_cnt, rxv_before);
        rx = 1'b1;
        wait_clks(2 * BIT_CLKS);
        check("break_no_byte_after_release", rxv_cnt, rxv_before);
        exp_q.push_back('{addr: 32'h0, din: 32'hAABB_CCDD, cnt: 11'd1});
        send_word(32'hAABB_CCDD, 1'b0);
        wait_clks(10);
        check("ferr_sticky", {31'd0, frame_err}, 32'd1);
        check("ferr_word_count", {21'd0, word_count}, 32'd1);

        // Start-bit glitch.
        rxv_before = rxv_cnt;
        rx = 1'b0;
        wait_clks(4);
        rx = 1'b1;
        wait_clks(2 * BIT_CLKS);
        check("glitch_no_byte", rxv_cnt, rxv_before);
        check("glitch_rx_idle", {29'd0, dut.u_rx.state_q}, {29'd0, RX_IDLE});
        exp_q.push_back('{addr: 32'h4, din: 32'hDEAD_BEEF, cnt: 11'd2});
        send_word(32'hDEAD_BEEF, 1'b0);
        wait_clks(10);
        check("glitch_then_bytes", rxv_cnt, rxv_before + 4);

        // Reset mid-word.
        send_byte(8'h55, 1'b1, 1'b0);
        send_byte(8'h66, 1'b1, 1'b0);
        reset = 1'b0;
        wait_clks(5);
        check("midrst_word_count", {21'd0, word_count}, 32'd0);
        reset = 1'b1;
        wait_clks(20);
        exp_q.push_back('{addr: 32'h0, din: 32'h0102_0304, cnt: 11'd1});
        send_word(32'h0102_0304, 1'b0);
        wait_clks(10);
        check("midrst_count_after", {21'd0, word_count}, 32'd1);

        // Capacity on the MAX_WORDS=2 instance.
        exp_c_q.push_back('{addr: 32'h0, din: 32'h1122_3344, cnt: 11'd1});
        send_word(32'h1122_3344, 1'b1);
        check("cap_not_done_yet", {31'd0, load_done_c}, 32'd0);
        exp_c_q.push_back('{addr: 32'h4, din: 32'h5566_7788, cnt: 11'd2});
        send_word(32'h5566_7788, 1'b1);
        wait_clks(10);
        check("cap_load_done", {31'd0, load_done_c}, 32'd1);
        check("cap_cpu_hold", {31'd0, cpu_hold_c}, 32'd0);
        check("cap_word_count", {21'd0, word_count_c}, 32'd2);
        send_word(32'h9999_9999, 1'b1);
        wait_clks(10);
        check("cap_word_count_after", {21'd0, word_count_c}, 32'd2);

        wait_clks(20);
        check("exp_queue_drained", exp_q.size(), 32'd0);
        check("cap_queue_drained", exp_c_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
